// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for a six-symbol code table latched on code_valid.
// Optional per-symbol decoded counters (DCNT1..DCNT6) are enabled by defining HUFF_DEC_HIST_EN.
module huffman_decoder #(
    parameter int N_SYM = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       sym_valid,
    output logic [7:0] sym_data,
    output logic       done,
    output logic       err
`ifdef HUFF_DEC_HIST_EN
    ,
    output logic [7:0] DCNT1,
    output logic [7:0] DCNT2,
    output logic [7:0] DCNT3,
    output logic [7:0] DCNT4,
    output logic [7:0] DCNT5,
    output logic [7:0] DCNT6
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t     state_q, state_d;
    logic [6:0] acc_q, acc_d;
    logic [3:0] len_q, len_d;
    logic [6:0] sym_cnt_q, sym_cnt_d;
    logic [7:0] hc_q [6];
    logic [7:0] hc_d [6];
    logic [7:0] m_q [6];
    logic [7:0] m_d [6];
    logic       sym_valid_q, sym_valid_d;
    logic [7:0] sym_data_q, sym_data_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] hc_in [6];
    logic [7:0] m_in [6];
    logic [7:0] acc_n;
    logic [3:0] len_n;
    logic [8:0] mask_wide;
    logic [7:0] mask_n;
    logic [5:0] match;
    logic [2:0] hit_k;

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    // The accumulator's top bit is shifted out before it could ever be compared, so only 7 bits are stored.
    assign acc_n     = {acc_q, bit_in};
    assign len_n     = len_q + 4'd1;
    assign mask_wide = (9'd1 << len_n) - 9'd1;
    assign mask_n    = mask_wide[7:0];

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_match
            assign match[gi] = (m_q[gi] == mask_n) && ((hc_q[gi] & m_q[gi]) == acc_n);
        end
    endgenerate

    // Lowest symbol index wins when the table is not prefix-free.
    always_comb begin
        hit_k = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (match[i]) hit_k = 3'(i + 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        sym_cnt_d   = sym_cnt_q;
        hc_d        = hc_q;
        m_d         = m_q;
        sym_valid_d = 1'b0;
        sym_data_d  = sym_data_q;
        done_d      = done_q;
        err_d       = err_q;
        if (code_valid) begin
            hc_d      = hc_in;
            m_d       = m_in;
            acc_d     = 7'd0;
            len_d     = 4'd0;
            sym_cnt_d = 7'd0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            state_d   = RUN;
        end else if (state_q == RUN && bit_valid) begin
            if (|match) begin
                sym_valid_d = 1'b1;
                sym_data_d  = {5'd0, hit_k};
                acc_d       = 7'd0;
                len_d       = 4'd0;
                if (sym_cnt_q != 7'd127) sym_cnt_d = sym_cnt_q + 7'd1;
                if (sym_cnt_d == 7'(N_SYM)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end else if (len_n == 4'd8) begin
                err_d   = 1'b1;
                state_d = ERR;
            end else begin
                acc_d = acc_n[6:0];
                len_d = len_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= 7'd0;
            len_q       <= 4'd0;
            sym_cnt_q   <= 7'd0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= 8'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hc_q[i] <= 8'd0;
                m_q[i]  <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            sym_cnt_q   <= sym_cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hc_q        <= hc_d;
            m_q         <= m_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef HUFF_DEC_HIST_EN
    logic [7:0] dcnt_all [6];

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hist
            logic [7:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (code_valid) begin
                    cnt_d = 8'd0;
                end else if (sym_valid_d && hit_k == 3'(gi + 1) && cnt_q != 8'd255) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) cnt_q <= 8'd0;
                else       cnt_q <= cnt_d;
            end

            assign dcnt_all[gi] = cnt_q;
        end
    endgenerate

    assign DCNT1 = dcnt_all[0];
    assign DCNT2 = dcnt_all[1];
    assign DCNT3 = dcnt_all[2];
    assign DCNT4 = dcnt_all[3];
    assign DCNT5 = dcnt_all[4];
    assign DCNT6 = dcnt_all[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder (N_SYM = 100).
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic [7:0] hc_t [6];
    logic [7:0] m_t [6];
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       done;
    logic       err;
    int         errors = 0;
    int         checks = 0;
`ifdef HUFF_DEC_HIST_EN
    logic [7:0] dcnt [6];
`endif

    always #5 clk = ~clk;

    huffman_decoder #(.N_SYM(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc_t[0]),
        .HC2        (hc_t[1]),
        .HC3        (hc_t[2]),
        .HC4        (hc_t[3]),
        .HC5        (hc_t[4]),
        .HC6        (hc_t[5]),
        .M1         (m_t[0]),
        .M2         (m_t[1]),
        .M3         (m_t[2]),
        .M4         (m_t[3]),
        .M5         (m_t[4]),
        .M6         (m_t[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .done       (done),
        .err        (err)
`ifdef HUFF_DEC_HIST_EN
        ,
        .DCNT1      (dcnt[0]),
        .DCNT2      (dcnt[1]),
        .DCNT3      (dcnt[2]),
        .DCNT4      (dcnt[3]),
        .DCNT5      (dcnt[4]),
        .DCNT6      (dcnt[5])
`endif
    );

    // Table T codes: 1, 01, 001, 0001, 00000, 00001
    function automatic void code_of(input int k, output logic [7:0] v, output int n);
        case (k)
            1:       begin v = 8'b1;     n = 1; end
            2:       begin v = 8'b01;    n = 2; end
            3:       begin v = 8'b001;   n = 3; end
            4:       begin v = 8'b0001;  n = 4; end
            5:       begin v = 8'b00000; n = 5; end
            default: begin v = 8'b00001; n = 5; end
        endcase
    endfunction

    task automatic set_table_t();
        hc_t[0] = 8'h01; m_t[0] = 8'h01;
        hc_t[1] = 8'h01; m_t[1] = 8'h03;
        hc_t[2] = 8'h01; m_t[2] = 8'h07;
        hc_t[3] = 8'h01; m_t[3] = 8'h0F;
        hc_t[4] = 8'h00; m_t[4] = 8'h1F;
        hc_t[5] = 8'h01; m_t[5] = 8'h1F;
    endtask

    task automatic set_table_err();
        hc_t[0] = 8'h01; m_t[0] = 8'h01;
        for (int i = 1; i < 6; i++) begin
            hc_t[i] = 8'(8'hFF - i + 1);
            m_t[i]  = 8'hFF;
        end
    endtask

    task automatic load(input logic bv, input logic b);
        @(negedge clk);
        code_valid = 1'b1;
        bit_valid  = bv;
        bit_in     = b;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_table_t();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({sym_valid, sym_data, done, err} !== 11'd0)
            $display("FAIL reset_outputs: got sv=%0b data=%0d done=%0b err=%0b, want all 0",
                     sym_valid, sym_data, done, err);
        step(1'b1);
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_bit_ignored: got sv=%0b, want 0", sym_valid);
        end
    endtask

    task automatic test_single();
        logic [7:0] v;
        int         n;
        set_table_t();
        load(1'b0, 1'b0);
        checks++;
        if ({sym_valid, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL load_quiet: got sv=%0b done=%0b err=%0b, want 0 0 0", sym_valid, done, err);
        end
        step(1'b1);
        checks++;
        if ({sym_valid, sym_data} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL single_sym1: got sv=%0b data=%0d, want sv=1 data=1", sym_valid, sym_data);
        end
        idle_cycle();
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got sv=%0b, want 0", sym_valid);
        end
        for (int k = 6; k >= 2; k--) begin
            code_of(k, v, n);
            for (int j = n - 1; j >= 0; j--) begin
                step(v[j]);
                checks++;
                if (j > 0) begin
                    if (sym_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL single_mid sym%0d bit%0d: got sv=%0b, want 0", k, j, sym_valid);
                    end
                end else if ({sym_valid, sym_data} !== {1'b1, 8'(k)}) begin
                    errors++;
                    $display("FAIL single_sym%0d: got sv=%0b data=%0d, want sv=1 data=%0d",
                             k, sym_valid, sym_data, k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_table_t();
        load(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            checks++;
            if ({sym_valid, sym_data} !== {1'b1, 8'd1}) begin
                errors++;
                $display("FAIL b2b_%0d: got sv=%0b data=%0d, want sv=1 data=1", i, sym_valid, sym_data);
            end
        end
    endtask

    task automatic test_err();
        set_table_err();
        load(1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(1'b0);
            checks++;
            if ({sym_valid, err} !== {1'b0, (j == 7)}) begin
                errors++;
                $display("FAIL err_bit%0d: got sv=%0b err=%0b, want sv=0 err=%0b",
                         j, sym_valid, err, (j == 7));
            end
        end
        for (int j = 0; j < 2; j++) begin
            step(1'b1);
            checks++;
            if ({sym_valid, err} !== 2'b01) begin
                errors++;
                $display("FAIL err_frozen%0d: got sv=%0b err=%0b, want sv=0 err=1", j, sym_valid, err);
            end
        end
        set_table_t();
        load(1'b0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err=%0b, want 0", err);
        end
        step(1'b1);
        checks++;
        if ({sym_valid, sym_data} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL err_recover: got sv=%0b data=%0d, want sv=1 data=1", sym_valid, sym_data);
        end
    endtask

    task automatic test_collide();
        set_table_t();
        load(1'b0, 1'b0);
        for (int j = 0; j < 3; j++) step(1'b0);
        load(1'b1, 1'b1);
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL collide_drop: got sv=%0b, want 0", sym_valid);
        end
        step(1'b1);
        checks++;
        if ({sym_valid, sym_data} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL collide_next1: got sv=%0b data=%0d, want sv=1 data=1", sym_valid, sym_data);
        end
        step(1'b0);
        step(1'b1);
        checks++;
        if ({sym_valid, sym_data} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL collide_next2: got sv=%0b data=%0d, want sv=1 data=2", sym_valid, sym_data);
        end
    endtask

    task automatic test_stream();
        logic [7:0] v;
        int         n;
        int         k;
        int         exp_cnt [6];
        for (int i = 0; i < 6; i++) exp_cnt[i] = 0;
        set_table_t();
        load(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            k = ((i * 5 + i / 3) % 6) + 1;
            exp_cnt[k-1]++;
            code_of(k, v, n);
            for (int j = n - 1; j >= 0; j--) begin
                step(v[j]);
                checks++;
                if (j > 0) begin
                    if (sym_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL stream_mid sym#%0d: got sv=%0b, want 0", i, sym_valid);
                    end
                end else if ({sym_valid, sym_data, done} !== {1'b1, 8'(k), (i == 99)}) begin
                    errors++;
                    $display("FAIL stream_sym#%0d: got sv=%0b data=%0d done=%0b, want sv=1 data=%0d done=%0b",
                             i, sym_valid, sym_data, done, k, (i == 99));
                end
            end
        end
        step(1'b1);
        checks++;
        if ({sym_valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL done_hold: got sv=%0b done=%0b, want sv=0 done=1", sym_valid, done);
        end
`ifdef HUFF_DEC_HIST_EN
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dcnt[i] !== 8'(exp_cnt[i])) begin
                errors++;
                $display("FAIL dcnt%0d: got %0d, want %0d", i + 1, dcnt[i], exp_cnt[i]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        checks++;
        if ({sym_valid, sym_data, done, err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_in_done: got sv=%0b data=%0d done=%0b err=%0b, want all 0",
                     sym_valid, sym_data, done, err);
        end
        step(1'b1);
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_idle: got sv=%0b, want 0", sym_valid);
        end
        set_table_t();
        load(1'b0, 1'b0);
        step(1'b0);
        step(1'b0);
        do_reset();
        checks++;
        if ({sym_valid, sym_data, done, err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_code: got sv=%0b data=%0d done=%0b err=%0b, want all 0",
                     sym_valid, sym_data, done, err);
        end
        step(1'b1);
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got sv=%0b, want 0", sym_valid);
        end
        load(1'b0, 1'b0);
        step(1'b1);
        checks++;
        if ({sym_valid, sym_data} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL reset_reload: got sv=%0b data=%0d, want sv=1 data=1", sym_valid, sym_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_err();
        test_collide();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
